sensor_event_fifo: RTL and testbench

Buffers the result codes that the sensor-link state machine produces, so that the Nios II can collect them later through a custom-instruction-style handshake. Data bytes, timeouts, checksum bugs and alarms all land here. Each rising edge of the producer's `done` becomes exactly one FIFO entry. The block sits directly downstream of the sensor-link FSM and upstream of the Nios custom-instruction slot, which drains it.

---
 rtl/sensor_event_fifo_pkg.sv | 26 ++
 rtl/sensor_event_fifo_if.sv | 10 +
 rtl/sensor_event_fifo_event_ring.sv | 89 ++++++++
 rtl/sensor_event_fifo.sv | 99 +++++++++
 tb/tb_sensor_event_fifo.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/sensor_event_fifo_pkg.sv
// Shared definitions for the sensor-link FSM and its event FIFO:
// result codes, checksum key and the Nios command encoding.
package sensor_pkg;

  localparam int CODE_W = 8;

  localparam logic [CODE_W-1:0] CODE_TIMEOUT = 8'h04;
  localparam logic [CODE_W-1:0] CODE_ALARM   = 8'h07;
  localparam logic [CODE_W-1:0] CODE_BUG     = 8'h0B;
  localparam logic [CODE_W-1:0] CHK_KEY      = 8'h37;

  typedef enum logic [1:0] {
    CMD_POP      = 2'd0,
    CMD_COUNT    = 2'd1,
    CMD_CLEAR    = 2'd2,
    CMD_RESERVED = 2'd3
  } cmd_e;

  // POP response word: [7:0] code, [14:8] count, [15] valid, [16] overflow.
  function automatic logic [31:0] pack_pop(input logic ovf, input logic valid,
                                           input logic [6:0] cnt,
                                           input logic [CODE_W-1:0] code);
    return {15'h0, ovf, valid, cnt, code};
  endfunction

endpackage

// File: rtl/sensor_event_fifo_if.sv
// Custom-instruction-style handshake between the Nios II and the event FIFO.
interface sensor_event_fifo_if;
  logic        enable;
  logic [31:0] dataa;
  logic [31:0] result;
  logic        done;

  modport master (output enable, output dataa, input result, input done);
  modport slave  (input enable, input dataa, output result, output done);
endinterface

// File: rtl/sensor_event_fifo_event_ring.sv
// Parameterised ring buffer with push, pop, flush and overwrite-oldest.
// Storage is plain RAM (not reset); pointers and count are reset.
module event_ring #(
  parameter int DEPTH = 8,
  parameter int W     = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  logic          allow_overwrite,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  rd_data,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_next,
  output logic          full,
  output logic          empty,
  output logic          lost
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          write_en;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign rd_data    = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;

  // Next pointer/count: flush beats everything, a push paired with a real pop never overflows.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    write_en = 1'b0;
    lost     = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (push && pop && !empty) begin
      write_en = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else if (push && !full) begin
      write_en = 1'b1;
      wr_ptr_d = wr_ptr_q + PW'(1);
      count_d  = count_q + CW'(1);
    end else if (push) begin
      lost = 1'b1;
      if (allow_overwrite) begin
        write_en = 1'b1;
        wr_ptr_d = wr_ptr_q + PW'(1);
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end else if (pop && !empty) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care after reset.
  always_ff @(posedge clock) begin
    if (write_en) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/sensor_event_fifo.sv
// Event FIFO between the sensor-link FSM and the Nios custom-instruction slot.
// Holds done-edge detection, the command decoder and the registered response.
module sensor_event_fifo
  import sensor_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [31:0]         ev_code,
  input  logic                ev_done,
  sensor_event_fifo_if.slave  nios,
  output logic                overflow
);

  logic              ev_done_q, ev_done_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       result_q, result_d;
  logic              done_q, done_d;

  logic              push_evt;
  logic              is_pop, is_clear;
  cmd_e              cmd;

  logic [CODE_W-1:0] ring_rd_data;
  logic [CW-1:0]     ring_count, ring_count_next;
  logic              ring_full, ring_empty, ring_lost;

  logic              unused_bits;

  assign unused_bits = ^{ev_code[31:CODE_W], nios.dataa[31:2], ring_full};

  assign cmd      = cmd_e'(nios.dataa[1:0]);
  assign is_pop   = nios.enable && (cmd == CMD_POP);
  assign is_clear = nios.enable && (cmd == CMD_CLEAR);
  assign push_evt = ev_done && !ev_done_q;

  event_ring #(
    .DEPTH (DEPTH),
    .W     (CODE_W),
    .CW    (CW)
  ) u_ring (
    .clock           (clock),
    .reset           (reset),
    .flush           (is_clear),
    .push            (push_evt),
    .pop             (is_pop),
    .allow_overwrite (ev_code[CODE_W-1:0] == CODE_ALARM),
    .push_data       (ev_code[CODE_W-1:0]),
    .rd_data         (ring_rd_data),
    .count           (ring_count),
    .count_next      (ring_count_next),
    .full            (ring_full),
    .empty           (ring_empty),
    .lost            (ring_lost)
  );

  // Decode the command and build next response, edge history and sticky overflow.
  always_comb begin
    ev_done_d  = ev_done;
    done_d     = nios.enable;
    result_d   = '0;
    overflow_d = overflow_q;
    if (is_clear) begin
      overflow_d = 1'b0;
    end else if (ring_lost) begin
      overflow_d = 1'b1;
    end
    if (nios.enable) begin
      case (cmd)
        CMD_POP:   result_d = pack_pop(overflow_q, !ring_empty, 7'(ring_count_next),
                                       ring_empty ? 8'h00 : ring_rd_data);
        CMD_COUNT: result_d = {23'h0, overflow_q, 8'(ring_count)};
        default:   result_d = '0;
      endcase
    end
  end

  // Output and control registers; reset also suppresses any same-cycle command.
  always_ff @(posedge clock) begin
    if (reset) begin
      ev_done_q  <= 1'b0;
      overflow_q <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      ev_done_q  <= ev_done_d;
      overflow_q <= overflow_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign nios.result = result_q;
  assign nios.done   = done_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_sensor_event_fifo.sv
// Scoreboard bench for sensor_event_fifo: commands push expected responses,
// a negedge monitor pops and compares whenever done is presented.
module tb_sensor_event_fifo;
  import sensor_pkg::*;

  typedef struct {
    logic [31:0] exp;
    logic [31:0] mask;
    string       name;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ev_code = '0;
  logic        ev_done = 1'b0;
  logic        overflow;
  logic        mon_en = 1'b0;

  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  exp_t        mon_e;

  sensor_event_fifo_if nios_if ();

  sensor_event_fifo #(.DEPTH(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .ev_code  (ev_code),
    .ev_done  (ev_done),
    .nios     (nios_if),
    .overflow (overflow)
  );

  // 50 MHz clock.
  always #10 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  // Issue one command for a single cycle and queue its expected response.
  task automatic applyStimulus(input cmd_e cmd, input logic [31:0] exp,
                               input logic [31:0] mask, input string name);
    @(negedge clock);
    nios_if.enable = 1'b1;
    nios_if.dataa  = {30'h15555555, cmd};
    exp_q.push_back('{exp, mask, name});
    @(negedge clock);
    nios_if.enable = 1'b0;
  endtask

  // Raise ev_done for 'hold' cycles carrying one code.
  task automatic pushEvent(input logic [7:0] code, input int hold);
    @(negedge clock);
    ev_code = {24'hA5A5A5, code};
    ev_done = 1'b1;
    repeat (hold) @(negedge clock);
    ev_done = 1'b0;
  endtask

  // Command and event rising edge sampled on the same clock edge.
  task automatic cmdWithEvent(input cmd_e cmd, input logic [7:0] code,
                              input logic [31:0] exp, input logic [31:0] mask,
                              input string name);
    @(negedge clock);
    ev_code        = {24'h0, code};
    ev_done        = 1'b1;
    nios_if.enable = 1'b1;
    nios_if.dataa  = {30'h0, cmd};
    exp_q.push_back('{exp, mask, name});
    @(negedge clock);
    nios_if.enable = 1'b0;
    ev_done        = 1'b0;
  endtask

  // Monitor: every done pulse consumes one expectation; idle cycles must show result 0.
  always @(negedge clock) begin
    if (mon_en) begin
      if (nios_if.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done actual=%h required=none", nios_if.result);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput(mon_e.name, nios_if.result & mon_e.mask, mon_e.exp & mon_e.mask);
        end
      end else begin
        checkOutput("idle_result", nios_if.result, 32'h0);
      end
    end
  end

  initial begin
    nios_if.enable = 1'b0;
    nios_if.dataa  = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_done", {31'h0, nios_if.done}, 32'h0);
    checkOutput("reset_result", nios_if.result, 32'h0);
    checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
    mon_en = 1'b1;

    applyStimulus(CMD_COUNT, 32'h0000_0000, '1, "count_after_reset");

    // Long done pulse is one entry.
    pushEvent(8'h5A, 5);
    applyStimulus(CMD_POP, 32'h0000_805A, '1, "pop_5a");
    applyStimulus(CMD_POP, 32'h0000_0000, '1, "pop_empty");

    // Fill, drop a non-alarm code, then overwrite oldest with an alarm.
    for (int i = 0; i < 8; i++) pushEvent(8'h10 + 8'(i), 1);
    pushEvent(CODE_TIMEOUT, 1);
    pushEvent(CODE_ALARM, 1);
    @(negedge clock);
    checkOutput("overflow_after_full", {31'h0, overflow}, 32'h1);
    applyStimulus(CMD_COUNT, 32'h0000_0108, '1, "count_full");
    for (int i = 1; i <= 8; i++) begin
      logic [7:0] code;
      code = (i < 8) ? 8'h10 + 8'(i) : CODE_ALARM;
      applyStimulus(CMD_POP, {15'h0, 1'b1, 1'b1, 7'(8 - i), code}, '1, "pop_drain");
    end
    applyStimulus(CMD_POP, 32'h0001_0000, '1, "pop_empty_ovf");
    applyStimulus(CMD_CLEAR, 32'h0, '1, "clear");
    @(negedge clock);
    checkOutput("overflow_after_clear", {31'h0, overflow}, 32'h0);

    // Simultaneous push + pop / count with three entries held.
    pushEvent(8'h31, 1);
    pushEvent(8'h32, 1);
    pushEvent(8'h33, 1);
    cmdWithEvent(CMD_POP, 8'h22, 32'h0000_8331, '1, "push_pop_same_cycle");
    applyStimulus(CMD_COUNT, 32'h0000_0003, '1, "count_after_push_pop");
    cmdWithEvent(CMD_COUNT, 8'h44, 32'h0000_0003, '1, "push_count_same_cycle");
    applyStimulus(CMD_COUNT, 32'h0000_0004, '1, "count_after_push_count");

    // Clear wins over an alarm push in the same cycle.
    cmdWithEvent(CMD_CLEAR, CODE_ALARM, 32'h0, '1, "push_clear_same_cycle");
    applyStimulus(CMD_COUNT, 32'h0000_0000, '1, "count_after_push_clear");
    checkOutput("overflow_after_push_clear", {31'h0, overflow}, 32'h0);

    // Push + pop on an empty FIFO: pop reports empty, push is kept.
    cmdWithEvent(CMD_POP, 8'h55, 32'h0, 32'hFFFF_80FF, "push_pop_empty");
    applyStimulus(CMD_COUNT, 32'h0000_0001, '1, "count_after_push_pop_empty");
    applyStimulus(CMD_POP, 32'h0000_8055, '1, "pop_55");

    // Reserved command and back-to-back commands.
    applyStimulus(CMD_RESERVED, 32'h0, '1, "reserved");
    @(negedge clock);
    nios_if.enable = 1'b1;
    nios_if.dataa  = {30'h0, CMD_COUNT};
    exp_q.push_back('{32'h0, '1, "b2b_count_a"});
    @(negedge clock);
    exp_q.push_back('{32'h0, '1, "b2b_count_b"});
    @(negedge clock);
    nios_if.enable = 1'b0;

    // Reset beats a same-cycle pop on a non-empty FIFO.
    pushEvent(8'h66, 1);
    @(negedge clock);
    nios_if.enable = 1'b1;
    nios_if.dataa  = {30'h0, CMD_POP};
    reset          = 1'b1;
    @(negedge clock);
    nios_if.enable = 1'b0;
    reset          = 1'b0;
    checkOutput("done_after_reset_pop", {31'h0, nios_if.done}, 32'h0);
    applyStimulus(CMD_COUNT, 32'h0000_0000, '1, "count_after_reset_pop");

    repeat (4) @(negedge clock);
    checkOutput("pending_responses", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
